// File: rtl/efuse_pkg.sv
// Shared types and defaults for the eFuse access arbiter.
//  - efuse_state_e : sequencer states
//  - DEF_T_*       : default setup/strobe/hold widths in cycles
//  - max3()        : helper used to size the shared timing counter
package efuse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } efuse_state_e;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 4;
  localparam int DEF_T_HOLD  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/efuse_rr_arb.sv
// Round-robin one-hot arbiter with a rotating priority pointer.
//  clk, rst : clock, asynchronous active-high reset (pointer -> channel 0)
//  en       : pointer advances only when en is high and some request wins
//  req      : per-channel request vector
//  gnt_oh   : combinational one-hot winner (first request at/after pointer)
module efuse_rr_arb #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt_oh
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win_idx;
  logic          w_found;
  int            w_idx;

  // Scan channels starting at the pointer, wrapping modulo NCH.
  always_comb begin
    gnt_oh    = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = (int'(r_ptr) + i) % NCH;
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        gnt_oh[w_idx] = 1'b1;
        w_win_idx     = PW'(w_idx);
      end
    end
  end

  // Winner gets lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (w_win_idx == PW'(NCH - 1)) ? '0 : w_win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/efuse_access_arb.sv
// Multi-channel eFuse access arbiter and timing sequencer.
// Handshake: a channel holds req (level); the arbiter answers with a one-hot
// gnt held from the grant cycle through the last HOLD cycle, then a single
// done pulse. req is only sampled in IDLE; dropping it mid-access is ignored.
//  clk/rst              : clock, asynchronous active-high reset
//  scan_mode            : gates all macro outputs to 0
//  reg_mode, rg_*       : software direct drive of the macro pins (IDLE only)
//  rg_rdata             : macro read data while the bypass is effective
//  req/we/addr          : per-channel request, program flag, address
//  gnt/done/rdata/busy  : grant, completion pulse, last read data, FSM active
//  efuse_*              : macro interface
//  dbg_state            : current sequencer state
module efuse_access_arb
  import efuse_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_mode,
  input  logic              reg_mode,
  input  logic              rg_pgmen,
  input  logic              rg_rden,
  input  logic              rg_aen,
  input  logic [AW-1:0]     rg_addr,
  output logic [DW-1:0]     rg_rdata,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              efuse_aen_o,
  output logic              efuse_rden_o,
  output logic              efuse_pgmen_o,
  output logic [AW-1:0]     efuse_addr_o,
  input  logic [DW-1:0]     efuse_rdata_i,
  output efuse_state_e      dbg_state
);

  if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1) begin : g_bad_timing
    $error("efuse_access_arb: T_SETUP, T_PULSE and T_HOLD must all be >= 1");
  end

  localparam int CW = $clog2(max3(T_SETUP, T_PULSE, T_HOLD) + 1);
  localparam logic [CW-1:0] SETUP_M1 = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_M1 = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(T_HOLD - 1);

  efuse_state_e     r_state;
  logic [CW-1:0]    r_cnt;
  logic [NCH-1:0]   r_gnt;
  logic [NCH-1:0]   r_done;
  logic             r_we;
  logic             r_aen;
  logic             r_rden;
  logic             r_pgmen;
  logic [AW-1:0]    r_addr_o;
  logic [DW-1:0]    r_cap;
  logic [DW-1:0]    r_rdata;

  logic [NCH-1:0]   w_win;
  logic             w_arb_en;
  logic             w_sel_we;
  logic [AW-1:0]    w_sel_addr;

  assign w_arb_en = (r_state == IDLE) && !reg_mode;

  efuse_rr_arb #(.NCH(NCH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (w_arb_en),
    .req    (req),
    .gnt_oh (w_win)
  );

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_win[i]) begin
        w_sel_we   = we[i];
        w_sel_addr = addr[i*AW +: AW];
      end
    end
  end

  // Every macro output is set on the edge that enters the state it belongs
  // to, so the pins are pure register outputs. Counters count down from
  // width-1 and reload on each state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_we     <= 1'b0;
      r_aen    <= 1'b0;
      r_rden   <= 1'b0;
      r_pgmen  <= 1'b0;
      r_addr_o <= '0;
      r_cap    <= '0;
      r_rdata  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_en && (|w_win)) begin
            r_state  <= SETUP;
            r_cnt    <= SETUP_M1;
            r_gnt    <= w_win;
            r_we     <= w_sel_we;
            r_aen    <= 1'b1;
            r_rden   <= 1'b0;
            r_pgmen  <= 1'b0;
            r_addr_o <= w_sel_addr;
          end else if (reg_mode) begin
            r_aen    <= rg_aen;
            r_rden   <= rg_rden;
            r_pgmen  <= rg_pgmen;
            r_addr_o <= rg_addr;
          end else begin
            r_aen    <= 1'b0;
            r_rden   <= 1'b0;
            r_pgmen  <= 1'b0;
            r_addr_o <= '0;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state <= STROBE;
            r_cnt   <= PULSE_M1;
            r_rden  <= ~r_we;
            r_pgmen <= r_we;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STROBE: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_M1;
            r_rden  <= 1'b0;
            r_pgmen <= 1'b0;
            r_cap   <= efuse_rdata_i;  // edge ending the last strobe cycle
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state  <= DONE;
            r_cnt    <= '0;
            r_aen    <= 1'b0;
            r_addr_o <= '0;
            r_gnt    <= '0;
            r_done   <= r_gnt;
            if (!r_we) r_rdata <= r_cap;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;
  assign efuse_aen_o   = r_aen   & ~scan_mode;
  assign efuse_rden_o  = r_rden  & ~scan_mode;
  assign efuse_pgmen_o = r_pgmen & ~scan_mode;
  assign efuse_addr_o  = scan_mode ? '0 : r_addr_o;
  assign rg_rdata      = (reg_mode && (r_state == IDLE)) ? efuse_rdata_i : '0;

endmodule
